// File: rtl/axi_wr_burst_gen.sv
// AXI write-side burst stimulus master: one INCR burst per command,
// address-derived byte pattern, B response folded into done/err.
module axi_wr_burst_gen #(
  parameter int TIDW  = 1,
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int USERW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [2:0]       cmd_size,
  input  logic [7:0]       cmd_len,
  input  logic [TIDW-1:0]  cmd_id,
  input  logic [7:0]       cmd_seed,
  output logic [AW-1:0]    axi_aw_addr,
  output logic [7:0]       axi_aw_len,
  output logic [2:0]       axi_aw_size,
  output logic [1:0]       axi_aw_burst,
  output logic [TIDW-1:0]  axi_aw_id,
  output logic             axi_aw_valid,
  input  logic             axi_aw_ready,
  output logic [TIDW-1:0]  axi_w_id,
  output logic [DW-1:0]    axi_w_data,
  output logic [DW/8-1:0]  axi_w_strb,
  output logic             axi_w_last,
  output logic [USERW-1:0] axi_w_user,
  output logic             axi_w_valid,
  input  logic             axi_w_ready,
  input  logic [TIDW-1:0]  axi_b_id,
  input  logic [1:0]       axi_b_resp,
  input  logic             axi_b_valid,
  output logic             axi_b_ready,
  output logic             done,
  output logic             err
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam logic [2:0] MAXSZ = 3'(LB);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state;
  logic [AW-1:0]   baddr_q;
  logic [2:0]      size_q;
  logic [7:0]      len_q;
  logic [7:0]      k_q;
  logic [7:0]      seed_q;
  logic [TIDW-1:0] id_q;

  logic [AW:0]     blk;
  logic [AW:0]     lo;
  logic [AW:0]     hi;
  logic [AW-1:0]   lane_base;
  logic            unused_b_id;

  assign unused_b_id = ^axi_b_id;

  // Beat covers [baddr, end of its size block); one extra bit holds the
  // carry when the block ends exactly at the top of the address space.
  assign blk       = (AW+1)'(1) << size_q;
  assign lo        = {1'b0, baddr_q};
  assign hi        = ({1'b0, baddr_q} & ~(blk - (AW+1)'(1))) + blk;
  assign lane_base = baddr_q & ~AW'(NB - 1);

  for (genvar j = 0; j < NB; j++) begin : g_lane
    logic [AW:0] la;
    assign la = {1'b0, lane_base} + (AW+1)'(j);
    assign axi_w_strb[j] = (la >= lo) && (la < hi);
    assign axi_w_data[8*j +: 8] =
      axi_w_strb[j] ? seed_q + la[7:0] : 8'h00;
  end

  assign cmd_ready    = (state == IDLE) && !rst;
  assign axi_aw_valid = (state == ADDR);
  assign axi_w_valid  = (state == DATA);
  assign axi_b_ready  = (state == RESP);

  assign axi_aw_addr  = baddr_q;
  assign axi_aw_len   = len_q;
  assign axi_aw_size  = size_q;
  assign axi_aw_burst = 2'b01;
  assign axi_aw_id    = id_q;
  assign axi_w_id     = id_q;
  assign axi_w_last   = (k_q == len_q);
  assign axi_w_user   = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baddr_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      seed_q  <= '0;
      id_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            baddr_q <= cmd_addr;
            size_q  <= cmd_size;
            len_q   <= cmd_len;
            id_q    <= cmd_id;
            seed_q  <= cmd_seed;
            k_q     <= '0;
            if (cmd_size > MAXSZ) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (axi_aw_ready) state <= DATA;
        end
        DATA: begin
          if (axi_w_ready) begin
            k_q     <= k_q + 8'd1;
            baddr_q <= hi[AW-1:0];
            if (k_q == len_q) state <= RESP;
          end
        end
        RESP: begin
          if (axi_b_valid) begin
            done  <= 1'b1;
            err   <= (axi_b_resp != 2'b00);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_burst_gen.md
# axi_wr_burst_gen

Upstream AXI write-side stimulus master for the axi2ahb bridge bench. Accepts one burst command at a time, drives a single INCR burst on the AXI AW/W channels (the same channels the byte logger and bridge consume), waits for the B response, then reports completion. Byte values come from a deterministic address-derived pattern, so downstream loggers and checkers predict every written byte without a side channel.

## Interface
- TIDW, 1, width of AXI ID fields
- AW, 32, address width
- DW, 64, data width in bits; DW/8 a power of two, at least 1 byte
- USERW, 1, width of WUSER
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  AW  start byte address; may be unaligned
- cmd_size  in  3  bytes per beat = 2^cmd_size
- cmd_len  in  8  beats minus one (AXI4 AWLEN)
- cmd_id  in  TIDW  transaction ID
- cmd_seed  in  8  pattern seed
- axi_aw_addr / axi_aw_len / axi_aw_size / axi_aw_burst / axi_aw_id  out  AW/8/3/2/TIDW  AW payload; burst fixed 2'b01
- axi_aw_valid  out  1;  axi_aw_ready  in  1
- axi_w_id / axi_w_data / axi_w_strb / axi_w_last / axi_w_user  out  TIDW/DW/DW/8/1/USERW  W payload; user tied 0
- axi_w_valid  out  1;  axi_w_ready  in  1
- axi_b_id / axi_b_resp  in  TIDW/2;  axi_b_valid  in  1;  axi_b_ready  out  1
- done  out  1  one-cycle pulse at end of each command
- err  out  1  qualifies done: illegal size or bresp != 2'b00

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready captures all cmd fields. If cmd_size > log2(DW/8): done=1, err=1 next cycle, stay IDLE, no AXI activity. Otherwise -> ADDR.
- ADDR: axi_aw_valid=1, payload = captured addr/len/size/id. On aw handshake -> DATA, beat counter k=0.
- DATA: axi_w_valid=1. Beat address: k=0 -> cmd_addr; k>0 -> (cmd_addr & ~(2^size-1)) + k*2^size, modulo 2^AW (wraps silently; 4 KB crossing is not checked).
- Strobe: lane j (0..DW/8-1) set iff lane byte address lies in [beat_addr, (beat_addr & ~(2^size-1)) + 2^size), with lane = byte address mod DW/8.
- Data: strobed lane j = cmd_seed + lane_addr[7:0] (mod 256), lane_addr = (beat_addr & ~(DW/8-1)) + j; unstrobed lanes 0.
- axi_w_last=1 iff k==cmd_len. Each w handshake increments k; handshake on last beat -> RESP.
- RESP: axi_b_ready=1. On b handshake: done=1 next cycle, err=(bresp!=0); axi_b_id is ignored for control. -> IDLE.

## Timing
- Reset (rst high at an edge): state IDLE, all valids 0, axi_b_ready 0, done 0, err 0, cmd_ready 0 while rst high, 1 the first cycle after. Reset mid-burst abandons the transaction; valids drop at that edge, no done.
- Cmd accepted at edge N -> axi_aw_valid=1 from cycle N+1.
- AW handshake at edge M -> axi_w_valid=1 from M+1; no AW/W overlap.
- W beats back-to-back when axi_w_ready held high: one beat per cycle.
- Payload stable while valid && !ready on every channel; valid never drops before handshake.
- Last W handshake at edge P -> axi_b_ready=1 from P+1.
- B handshake at edge Q -> done/err valid cycle Q+1; cmd_ready=1 in Q+1 (new command may be captured at the edge ending Q+1).
- Minimum command turnaround with all readies high: 1 (ADDR) + (len+1) (DATA) + 1 (RESP) + 1 (IDLE) cycles.
- axi_b_valid arriving before RESP is not acknowledged until RESP.

## Test plan
- DW=64, addr 0x1003, size 2, len 2, seed 0x00 -> beats: strb 0x08 lane3=0x03; strb 0xF0 bytes 04..07; strb 0x0F bytes 08..0B with wlast; done=1, err=0.
- Same command, axi_w_ready low 3 cycles on beat 1 -> wvalid held, data/strb unchanged for 3 cycles, beat accepted on 4th, total 3 beats.
- addr 0xFFFFFFFC, size 2, len 1, seed 0x10 -> beat0 strb 0xF0 bytes 0C..0F; beat1 addr 0x00000000 strb 0x0F bytes 10..13.
- cmd_size 4 with DW=64 -> done=1, err=1 one cycle after accept, axi_aw_valid never asserted.
- bresp=2'b10 on a len 0 burst -> done=1, err=1; next command accepted on following cycle.
- rst high during beat 1 of a len 3 burst -> valids 0 next cycle, no done, cmd_ready=1 after rst drops.
